mux_stream_n: RTL
=================

# mux_stream_n

Parametrised, registered N-channel stream multiplexer, the successor to the team's combinational 4:1 bit mux. It merges CHANNELS valid/ready input streams of WIDTH bits onto one output stream. Selection is either a fixed select input (MODE 0) or round-robin arbitration (MODE 1). A channel holds the grant for a whole packet, from the first beat up to and including its `last` beat. The output is registered, and the block sits between packet producers and a shared downstream consumer.

## Interface
- WIDTH, 8, data bits per beat (≥1)
- CHANNELS, 4, number of input streams (2..16)
- MODE, 0, 0 = channel chosen by S; 1 = round-robin among valid channels
- SEL_W, $clog2(CHANNELS), width of S and O_sel (derived; do not override)

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- S  in  SEL_W  channel select; sampled only at packet start, and only used in MODE 0
- I_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- I_valid  in  CHANNELS  per-channel beat valid
- I_last  in  CHANNELS  per-channel end-of-packet flag
- I_ready  out  CHANNELS  per-channel accept; at most one bit high in any cycle
- O_data  out  WIDTH  registered output data
- O_valid  out  1  registered output valid
- O_last  out  1  registered end-of-packet
- O_sel  out  SEL_W  index of the channel that sourced the current O_data
- O_ready  in  1  downstream accept

## Operation
- A transfer happens on an edge where valid and ready are both high. The rule applies on each side independently.
- out_free = !O_valid || O_ready. The output register loads only when out_free is high.
- State IDLE (no lock): pick candidate channel c.
  - MODE 0: c = S. If S ≥ CHANNELS, there is no candidate and all I_ready bits are 0.
  - MODE 1: c is the first channel with I_valid=1, searching upward from rr_ptr+1 modulo CHANNELS. If no channel is valid, there is no candidate.
  - I_ready[c] = out_free. All other I_ready bits are 0.
  - On a transfer: load O_data/O_last/O_sel from c and set O_valid=1. In MODE 1, set rr_ptr = c.
  - If the beat had I_last=0, go to LOCKED(c). If I_last=1, stay in IDLE (single-beat packet).
- State LOCKED(k): I_ready[k] = out_free. All other I_ready bits are 0.
  - S and the other channels' valids are ignored.
  - On transfer of a beat with I_last[k]=1, return to IDLE. That beat is loaded normally.
- Output hold: when O_valid=1 and O_ready=0, O_data, O_last and O_sel stay stable.
- No-load cycle with O_ready=1: if out_free is high but no input transfer occurs, O_valid goes to 0 on the next edge. O_data, O_last and O_sel keep their old values.
- Round-robin fairness (MODE 1): a continuously valid channel waits at most CHANNELS-1 packets before it is granted.
- Reset:
  - O_valid=0, O_last=0, O_data=0, O_sel=0.
  - State = IDLE.
  - rr_ptr = CHANNELS-1, so channel 0 has priority on the first grant.
  - I_ready is all 0 during the reset cycle.

## Timing
- Latency: an input beat accepted at edge n appears on O_* after edge n and is valid in cycle n+1.
- Throughput: one beat per cycle when O_ready is held at 1.
- I_ready is combinational from state, S, I_valid, O_valid and O_ready. It has no combinational path from I_data.
- Back-to-back packets: in the cycle after a last beat is accepted, IDLE arbitration runs, so a new packet can be accepted with no bubble.
- Simultaneous events:
  - O_ready=1 together with a new input transfer: the register is reloaded and O_valid stays 1.
  - A change on S while LOCKED has no effect until return to IDLE.
- Reset mid-packet: the lock is dropped and the in-flight output beat is discarded. O_valid is 0 in the cycle after the rst edge, and the remainder of the packet is not forwarded. Upstream sources are responsible for resynchronising.
- Channel deasserts I_valid while LOCKED: the block stalls with the lock held. No other channel is granted.

## Test plan
- MODE 0, CHANNELS=4, WIDTH=8, S=2, ch2 sends 0x11,0x22,0x33 (last on 0x33) with O_ready=1 -> O_data 0x11,0x22,0x33 on three consecutive cycles, each one cycle after acceptance. O_sel=2 and O_last=1 only on 0x33.
- MODE 0, S switched 2→1 after the first beat of a 3-beat ch2 packet -> the remaining ch2 beats are still forwarded and I_ready[1]=0 until the ch2 last beat. The next accepted packet comes from ch1.
- MODE 1, all four channels continuously valid with single-beat packets (data = 0xA0+k) -> O_sel sequence 0,1,2,3,0,… with no idle cycles.
- Backpressure: O_ready=0 for 3 cycles mid-packet -> O_data and O_sel stay stable, I_ready is all 0 after the register fills, and no beat is lost or duplicated after O_ready returns to 1.
- CHANNELS=3, MODE 0, S=3 -> I_ready=0 on all channels and O_valid stays 0.
- Assert rst in the middle of a 4-beat packet -> O_valid=0 and O_sel=0 the next cycle. The state is IDLE, and in MODE 1 the next grant goes to the lowest-index valid channel.

Source files
------------

// File: rtl/mux_stream_n.sv
// Registered N-channel valid/ready stream multiplexer with packet-granular locking.
// Channel is chosen by S (MODE 0) or round-robin among valid inputs (MODE 1).
module mux_stream_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          S,
  input  logic [CHANNELS*WIDTH-1:0] I_data,
  input  logic [CHANNELS-1:0]       I_valid,
  input  logic [CHANNELS-1:0]       I_last,
  output logic [CHANNELS-1:0]       I_ready,
  output logic [WIDTH-1:0]          O_data,
  output logic                      O_valid,
  output logic                      O_last,
  output logic [SEL_W-1:0]          O_sel,
  input  logic                      O_ready
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_lock_ch;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [WIDTH-1:0] r_data_p1;
  logic             r_vld_p1;
  logic             r_last_p1;
  logic [SEL_W-1:0] r_sel_p1;

  logic             w_out_free;
  logic             w_cand_vld;
  logic [SEL_W-1:0] w_cand_ch;
  logic [SEL_W:0]   w_pick;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_ch;
  logic             w_xfer;
  logic             w_beat_last;
  logic [WIDTH-1:0] w_beat_data;

  // Returns {found, index}: first valid channel searching upward from ptr+1, wrapping.
  function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0]    ptr,
                                              input logic [CHANNELS-1:0] vld);
    logic [SEL_W:0] res;
    int             idx;
    res = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (vld[idx]) res = {1'b1, SEL_W'(idx)};
    end
    return res;
  endfunction

  assign w_out_free = !r_vld_p1 || O_ready;

  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_ch  = '0;
    w_pick     = rr_pick(r_rr_ptr, I_valid);
    if (MODE == 0) begin
      w_cand_vld = (int'(S) < CHANNELS);
      w_cand_ch  = S;
    end else begin
      w_cand_vld = w_pick[SEL_W];
      w_cand_ch  = w_pick[SEL_W-1:0];
    end
  end

  always_comb begin
    w_grant_vld = w_cand_vld;
    w_grant_ch  = w_cand_ch;
    if (r_state == ST_LOCKED) begin
      w_grant_vld = 1'b1;
      w_grant_ch  = r_lock_ch;
    end
  end

  // Ready depends only on control state, never on I_data.
  always_comb begin
    I_ready = '0;
    if (!rst && w_grant_vld && w_out_free) I_ready[w_grant_ch] = 1'b1;
  end

  assign w_xfer      = |(I_ready & I_valid);
  assign w_beat_last = I_last[w_grant_ch];
  assign w_beat_data = I_data[int'(w_grant_ch)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && !w_beat_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_xfer && w_beat_last)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_rr_ptr  <= SEL_W'(CHANNELS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_xfer) begin
        r_lock_ch <= w_grant_ch;
        if (MODE != 0) r_rr_ptr <= w_grant_ch;
      end
    end
  end

  // Stage p1: output register, loads only when downstream can take a new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_last_p1 <= 1'b0;
      r_sel_p1  <= '0;
    end else if (w_out_free) begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_data_p1 <= w_beat_data;
        r_last_p1 <= w_beat_last;
        r_sel_p1  <= w_grant_ch;
      end
    end
  end

  assign O_data  = r_data_p1;
  assign O_valid = r_vld_p1;
  assign O_last  = r_last_p1;
  assign O_sel   = r_sel_p1;

endmodule
